// File: rtl/delay_line_bank_if.sv
// delay_line_bank_if: request/response bus of the delay-line bank
interface delay_line_bank_if #(
  parameter int TANK_AW    = 5,
  parameter int WORD_AW    = 4,
  parameter int WORD_WIDTH = 36
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [TANK_AW-1:0]    req_tank;
  logic [WORD_AW-1:0]    req_word;
  logic [WORD_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [WORD_WIDTH-1:0] rsp_rdata;
  logic                  mob;
  logic [WORD_AW-1:0]    slot;
  modport master (
    output req_valid, req_we, req_tank, req_word, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, mob, slot
  );
  modport slave (
    input  req_valid, req_we, req_tank, req_word, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, mob, slot
  );
endinterface

// File: rtl/delay_line_bank.sv
// delay_line_bank: bank of recirculating serial delay-line tanks with slot-aligned word transfers; MONITOR_EN adds a raw tank monitor
module delay_line_bank #(
  parameter int  NUM_TANKS      = 32,
  parameter int  WORDS_PER_TANK = 16,
  parameter int  WORD_WIDTH     = 36,
  localparam int TANK_AW        = NUM_TANKS > 1 ? $clog2(NUM_TANKS) : 1,
  localparam int WORD_AW        = WORDS_PER_TANK > 1 ? $clog2(WORDS_PER_TANK) : 1,
  localparam int TANK_LEN       = WORDS_PER_TANK * WORD_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef MONITOR_EN
  input  logic [TANK_AW-1:0]  mon_tank,
  output logic [TANK_LEN-1:0] monitor,
`endif
  delay_line_bank_if.slave    bus
);
  localparam int BIT_AW = WORD_WIDTH > 1 ? $clog2(WORD_WIDTH) : 1;
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, XFER = 2'd2, DONE = 2'd3;
  logic [1:0]            st_q, st_d;
  logic [BIT_AW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_AW-1:0]    word_cnt_q, word_cnt_d;
  logic                  we_q, we_d;
  logic [TANK_AW-1:0]    tgt_q, tgt_d;
  logic [WORD_AW-1:0]    word_q, word_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
  logic [TANK_LEN-1:0]   tank_q [NUM_TANKS];
  logic [TANK_LEN-1:0]   tank_d [NUM_TANKS];
  logic                  accept, active, last_bit, head;
  // shared bit/word position of the bit currently at every tank head
  always_comb begin
    last_bit   = bit_cnt_q == BIT_AW'(WORD_WIDTH - 1);
    bit_cnt_d  = last_bit ? '0 : bit_cnt_q + 1'b1;
    word_cnt_d = !last_bit ? word_cnt_q :
                 word_cnt_q == WORD_AW'(WORDS_PER_TANK - 1) ? '0 : word_cnt_q + 1'b1;
  end
  // transfer FSM; the first transfer bit happens in the WAIT cycle that sees the slot's bit 0
  always_comb begin
    accept  = st_q == IDLE && bus.req_valid;
    active  = st_q == XFER || (st_q == WAIT && word_cnt_q == word_q && bit_cnt_q == '0);
    st_d    = accept ? WAIT : active ? (last_bit ? DONE : XFER) : st_q == DONE ? IDLE : st_q;
    we_d    = accept ? bus.req_we : we_q;
    tgt_d   = accept ? bus.req_tank : tgt_q;
    word_d  = accept ? bus.req_word : word_q;
    wdata_d = accept ? bus.req_wdata : wdata_q;
    rdata_d = accept ? '0 : active ? {head, rdata_q[WORD_WIDTH-1:1]} : rdata_q;
  end
  // rotate every tank one bit; only the in-range target tank takes write data at its tail
  always_comb begin
    head = 1'b0;
    for (int t = 0; t < NUM_TANKS; t++) begin
      head |= tgt_q == TANK_AW'(t) && tank_q[t][0];
      tank_d[t] = {(active && we_q && tgt_q == TANK_AW'(t)) ? wdata_q[bit_cnt_q] : tank_q[t][0],
                   tank_q[t][TANK_LEN-1:1]};
    end
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q       <= IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      we_q       <= 1'b0;
      tgt_q      <= '0;
      word_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      tank_q     <= '{default: '0};
    end else begin
      st_q       <= st_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      we_q       <= we_d;
      tgt_q      <= tgt_d;
      word_q     <= word_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      tank_q     <= tank_d;
    end
  end
`ifdef MONITOR_EN
  // raw view of the selected tank, zero when the index is out of range
  always_comb begin
    monitor = '0;
    for (int t = 0; t < NUM_TANKS; t++)
      if (mon_tank == TANK_AW'(t)) monitor = tank_q[t];
  end
`endif
  assign bus.req_ready = st_q == IDLE;
  assign bus.rsp_valid = st_q == DONE;
  assign bus.rsp_rdata = rdata_q;
  assign bus.mob       = active && head;
  assign bus.slot      = word_cnt_q;
endmodule

// File: tb/tb_delay_line_bank.sv
// tb_delay_line_bank: directed self-checking bench for a 4 tank x 4 word x 8 bit delay_line_bank
module tb_delay_line_bank;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  always #5 clk = ~clk;
  delay_line_bank_if #(.TANK_AW(2), .WORD_AW(2), .WORD_WIDTH(8)) bus ();
`ifdef MONITOR_EN
  logic [1:0]  mon_tank = 2'd3;
  logic [31:0] monitor;
  logic [31:0] m0;
`endif
  delay_line_bank #(.NUM_TANKS(4), .WORDS_PER_TANK(4), .WORD_WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef MONITOR_EN
    .mon_tank(mon_tank),
    .monitor(monitor),
`endif
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_slot(input logic [1:0] s);
    int n = 0;
    while (bus.slot == s && n < 200) begin @(negedge clk); n++; end
    while (bus.slot != s && n < 200) begin @(negedge clk); n++; end
    chk("wait_slot", bus.slot, s);
  endtask

  // mode 0: next cycle; 1: accept one cycle before slot 2 bit 0; 2: accept at slot 2 bit 0
  task automatic xfer(input string tag, input int mode, input logic we, input logic [1:0] tank,
                      input logic [1:0] word, input logic [7:0] wdata, input logic [7:0] exp_rdata,
                      input int exp_lat);
    int lat = 0;
    logic [7:0] hist = '0;
    if (mode == 1) begin wait_slot(1); repeat (7) @(negedge clk); end
    else if (mode == 2) wait_slot(2);
    else @(negedge clk);
    chk({tag, " ready"}, bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_tank  = tank;
    bus.req_word  = word;
    bus.req_wdata = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = ~we;
    bus.req_tank  = ~tank;
    bus.req_word  = ~word;
    bus.req_wdata = ~wdata;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid) break;
      hist = {bus.mob, hist[7:1]};
    end
    chk({tag, " rsp_valid"}, bus.rsp_valid, 1);
    chk({tag, " rsp_rdata"}, bus.rsp_rdata, exp_rdata);
    chk({tag, " mob"}, hist, exp_rdata);
    if (exp_lat > 0) chk({tag, " latency"}, lat, exp_lat);
    @(negedge clk);
    chk({tag, " pulse"}, bus.rsp_valid, 0);
    chk({tag, " ready_after"}, bus.req_ready, 1);
    chk({tag, " rdata_held"}, bus.rsp_rdata, exp_rdata);
  endtask

  initial begin
    int seen;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_tank  = '0;
    bus.req_word  = '0;
    bus.req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready", bus.req_ready, 1);
    chk("reset rsp_valid", bus.rsp_valid, 0);
    chk("reset rdata", bus.rsp_rdata, 0);
    chk("reset mob", bus.mob, 0);
    chk("reset slot", bus.slot, 0);
    rst_n = 1'b1;
    xfer("rd t2w3", 0, 1'b0, 2'd2, 2'd3, 8'h00, 8'h00, 0);
    xfer("wr t1w2", 0, 1'b1, 2'd1, 2'd2, 8'hA5, 8'h00, 0);
    xfer("rd t1w2", 0, 1'b0, 2'd1, 2'd2, 8'h00, 8'hA5, 0);
    xfer("wr early", 1, 1'b1, 2'd3, 2'd2, 8'h5A, 8'h00, 9);
    xfer("wr late", 2, 1'b1, 2'd3, 2'd2, 8'h3C, 8'h5A, 40);
    xfer("wr t0w0 ff", 0, 1'b1, 2'd0, 2'd0, 8'hFF, 8'h00, 0);
    xfer("wr t0w0 3c", 0, 1'b1, 2'd0, 2'd0, 8'h3C, 8'hFF, 0);
    xfer("rd t0w0", 0, 1'b0, 2'd0, 2'd0, 8'h00, 8'h3C, 0);
    xfer("rd t1w2 again", 0, 1'b0, 2'd1, 2'd2, 8'h00, 8'hA5, 0);
    xfer("rd t3w2", 0, 1'b0, 2'd3, 2'd2, 8'h00, 8'h3C, 0);
    xfer("rd t2w3 again", 0, 1'b0, 2'd2, 2'd3, 8'h00, 8'h00, 0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_tank  = 2'd2;
    bus.req_word  = 2'd1;
    bus.req_wdata = 8'h77;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    wait_slot(1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    seen = 0;
    @(negedge clk);
    seen += int'(bus.rsp_valid);
    chk("midrst ready", bus.req_ready, 1);
    chk("midrst rdata", bus.rsp_rdata, 0);
    chk("midrst mob", bus.mob, 0);
    chk("midrst slot", bus.slot, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      seen += int'(bus.rsp_valid);
      if (i == 7) chk("restart slot0", bus.slot, 0);
      if (i == 8) chk("restart slot1", bus.slot, 1);
    end
    chk("midrst no rsp", seen, 0);
    xfer("post rst t2w1", 0, 1'b0, 2'd2, 2'd1, 8'h00, 8'h00, 0);
    xfer("post rst t1w2", 0, 1'b0, 2'd1, 2'd2, 8'h00, 8'h00, 0);
    xfer("post rst t0w0", 0, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 0);
`ifdef MONITOR_EN
    xfer("wr t3w1 81", 0, 1'b1, 2'd3, 2'd1, 8'h81, 8'h00, 0);
    @(negedge clk);
    m0 = monitor;
    chk("mon ones", $countones(m0), 2);
    @(negedge clk);
    chk("mon rotate", monitor, {m0[0], m0[31:1]});
    repeat (31) @(negedge clk);
    chk("mon period", monitor, m0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
